// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Two-master to one-slave Avalon arbiter between the instruction-side (port 0)
// and data-side (port 1) caches and the shared memory bus.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-high
//   p0_avn_req_i   port 0 (icache) request
//   p0_avn_resp_o  port 0 response (readdata, waitrequest)
//   p1_avn_req_i   port 1 (dcache) request
//   p1_avn_resp_o  port 1 response
//   mem_avn_req_o  merged request to memory
//   mem_avn_resp_i memory response
//
// State table:
//   IDLE   | arbitrate combinationally among requesting ports each cycle
//   LOCKED | granted transfer stalled by waitrequest; grant held in gnt_id_q

package cache_mem_arbiter_pkg;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic                    read;
        logic                    write;
        logic [DATA_WIDTH-1:0]   address;
        logic [DATA_WIDTH/8-1:0] byte_enable;
        logic [DATA_WIDTH-1:0]   writedata;
    } avalon_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] readdata;
        logic                  waitrequest;
    } avalon_resp_t;
endpackage

module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  avalon_req_t  p0_avn_req_i,
    output avalon_resp_t p0_avn_resp_o,
    input  avalon_req_t  p1_avn_req_i,
    output avalon_resp_t p1_avn_resp_o,
    output avalon_req_t  mem_avn_req_o,
    input  avalon_resp_t mem_avn_resp_i
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state_q, state_d;
    logic   gnt_id_q, gnt_id_d;
    logic   last_grant_q, last_grant_d;

    // Read-return pipe: entry READ_LATENCY-1 is aligned with memory readdata.
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_id_q;

    logic        req0, req1;
    logic        gnt;
    logic        gnt_active;
    logic        fwd_req;
    logic        accept;
    logic        rd_accept;
    avalon_req_t fwd;
    logic        tail_vld, tail_id;

    assign req0     = p0_avn_req_i.read | p0_avn_req_i.write;
    assign req1     = p1_avn_req_i.read | p1_avn_req_i.write;
    assign tail_vld = pipe_vld_q[READ_LATENCY-1];
    assign tail_id  = pipe_id_q[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            pipe_vld_q   <= '0;
            pipe_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_id_q      <= gnt_id_d;
            last_grant_q  <= last_grant_d;
            pipe_vld_q[0] <= rd_accept;
            pipe_id_q[0]  <= gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        gnt          = 1'b0;
        gnt_active   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_active = req0 | req1;
                if (req0 & req1) begin
                    gnt = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
                end else begin
                    gnt = req1;
                end
            end
            LOCKED: begin
                gnt        = gnt_id_q;
                gnt_active = 1'b1;
            end
            default: begin
                gnt        = 1'b0;
                gnt_active = 1'b0;
            end
        endcase

        // With no request, port 0 is selected so the idle bus carries port 0
        // address/data with read and write already low.
        fwd       = gnt ? p1_avn_req_i : p0_avn_req_i;
        fwd_req   = fwd.read | fwd.write;
        accept    = fwd_req & ~mem_avn_resp_i.waitrequest;
        rd_accept = fwd.read & ~mem_avn_resp_i.waitrequest;

        if (accept) begin
            last_grant_d = gnt;
        end

        case (state_q)
            IDLE: begin
                if (fwd_req && mem_avn_resp_i.waitrequest) begin
                    state_d  = LOCKED;
                    gnt_id_d = gnt;
                end
            end
            LOCKED: begin
                // A dropped request while locked releases the lock without
                // touching last_grant, since nothing was accepted.
                if (!fwd_req || !mem_avn_resp_i.waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_avn_req_o = fwd;

        p0_avn_resp_o.waitrequest = (gnt_active && !gnt) ? mem_avn_resp_i.waitrequest : req0;
        p1_avn_resp_o.waitrequest = (gnt_active &&  gnt) ? mem_avn_resp_i.waitrequest : req1;
        p0_avn_resp_o.readdata    = (tail_vld && !tail_id) ? mem_avn_resp_i.readdata : '0;
        p1_avn_resp_o.readdata    = (tail_vld &&  tail_id) ? mem_avn_resp_i.readdata : '0;

        // Reset acts on the outputs immediately, not at the next edge.
        if (rst) begin
            mem_avn_req_o.read        = 1'b0;
            mem_avn_req_o.write       = 1'b0;
            p0_avn_resp_o.waitrequest = 1'b1;
            p1_avn_resp_o.waitrequest = 1'b1;
            p0_avn_resp_o.readdata    = '0;
            p1_avn_resp_o.readdata    = '0;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter. Three instances share stimulus:
// default (round-robin, latency 1), fixed priority, and read latency 3.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    avalon_req_t  p0_req, p1_req;
    avalon_resp_t mem_resp;

    avalon_resp_t d_p0_resp, d_p1_resp, f_p0_resp, f_p1_resp, l_p0_resp, l_p1_resp;
    avalon_req_t  d_mem_req, f_mem_req, l_mem_req;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.FIXED_PRIORITY(1'b0), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .p0_avn_req_i(p0_req), .p0_avn_resp_o(d_p0_resp),
        .p1_avn_req_i(p1_req), .p1_avn_resp_o(d_p1_resp),
        .mem_avn_req_o(d_mem_req), .mem_avn_resp_i(mem_resp)
    );

    cache_mem_arbiter #(.FIXED_PRIORITY(1'b1), .READ_LATENCY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_avn_req_i(p0_req), .p0_avn_resp_o(f_p0_resp),
        .p1_avn_req_i(p1_req), .p1_avn_resp_o(f_p1_resp),
        .mem_avn_req_o(f_mem_req), .mem_avn_resp_i(mem_resp)
    );

    cache_mem_arbiter #(.FIXED_PRIORITY(1'b0), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .p0_avn_req_i(p0_req), .p0_avn_resp_o(l_p0_resp),
        .p1_avn_req_i(p1_req), .p1_avn_resp_o(l_p1_resp),
        .mem_avn_req_o(l_mem_req), .mem_avn_resp_i(mem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle_all();
        p0_req   = '0;
        p1_req   = '0;
        mem_resp = '0;
    endtask

    task automatic drive_p0(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        p0_req = '{read: rd, write: wr, address: addr, byte_enable: 4'hF, writedata: data};
    endtask

    task automatic drive_p1(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        p1_req = '{read: rd, write: wr, address: addr, byte_enable: 4'hF, writedata: data};
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        drive_p0(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        #3;
        chk("rst_mem_read", 32'(d_mem_req.read), 32'd0);
        chk("rst_p0_wait", 32'(d_p0_resp.waitrequest), 32'd1);
        chk("rst_p1_wait", 32'(d_p1_resp.waitrequest), 32'd1);
        chk("rst_p0_rdata", d_p0_resp.readdata, 32'h0);
        step();
        rst = 1'b0;
        idle_all();
        #3;

        // Single master read
        step();
        drive_p0(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        #3;
        chk("single_mem_read", 32'(d_mem_req.read), 32'd1);
        chk("single_mem_addr", d_mem_req.address, 32'h0000_0100);
        chk("single_p0_wait", 32'(d_p0_resp.waitrequest), 32'd0);
        chk("single_p1_wait", 32'(d_p1_resp.waitrequest), 32'd0);
        step();
        idle_all();
        mem_resp.readdata = 32'hDEAD_BEEF;
        #3;
        chk("single_p0_rdata", d_p0_resp.readdata, 32'hDEAD_BEEF);
        chk("single_p1_rdata", d_p1_resp.readdata, 32'h0);

        // Round-robin conflict: grants p0,p1,p0,p1; data follows one cycle later
        step();
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle_all();
            if (k < 4) begin
                drive_p0(1'b1, 1'b0, 32'h10, 32'h0);
                drive_p1(1'b1, 1'b0, 32'h20, 32'h0);
            end
            mem_resp.readdata = 32'hA000 + 32'(k);
            #3;
            if (k < 4) begin
                chk($sformatf("rr_addr_%0d", k), d_mem_req.address, (k % 2 == 0) ? 32'h10 : 32'h20);
                chk($sformatf("rr_p0_wait_%0d", k), 32'(d_p0_resp.waitrequest), (k % 2 == 0) ? 32'd0 : 32'd1);
                chk($sformatf("rr_p1_wait_%0d", k), 32'(d_p1_resp.waitrequest), (k % 2 == 0) ? 32'd1 : 32'd0);
            end
            if (k > 0) begin
                chk($sformatf("rr_p0_rdata_%0d", k), d_p0_resp.readdata, ((k - 1) % 2 == 0) ? 32'hA000 + 32'(k) : 32'h0);
                chk($sformatf("rr_p1_rdata_%0d", k), d_p1_resp.readdata, ((k - 1) % 2 == 1) ? 32'hA000 + 32'(k) : 32'h0);
            end
            step();
        end

        // Stall lock: p1 write held through 3 waitrequest cycles, p0 joins at cycle 1
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle_all();
            if (k < 4) drive_p1(1'b0, 1'b1, 32'h200, 32'h1234_5678);
            if (k >= 1) drive_p0(1'b1, 1'b0, 32'h300, 32'h0);
            mem_resp.waitrequest = (k < 3);
            #3;
            if (k < 4) begin
                chk($sformatf("lock_write_%0d", k), 32'(d_mem_req.write), 32'd1);
                chk($sformatf("lock_addr_%0d", k), d_mem_req.address, 32'h200);
                chk($sformatf("lock_wdata_%0d", k), d_mem_req.writedata, 32'h1234_5678);
                chk($sformatf("lock_p1_wait_%0d", k), 32'(d_p1_resp.waitrequest), (k < 3) ? 32'd1 : 32'd0);
                chk($sformatf("lock_p0_wait_%0d", k), 32'(d_p0_resp.waitrequest), (k >= 1) ? 32'd1 : 32'd0);
            end else begin
                chk("lock_p0_read", 32'(d_mem_req.read), 32'd1);
                chk("lock_p0_addr", d_mem_req.address, 32'h300);
                chk("lock_p0_wait", 32'(d_p0_resp.waitrequest), 32'd0);
            end
            step();
        end

        // Fixed priority: p0 wins every conflict
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle_all();
            drive_p0(1'b1, 1'b0, 32'h50, 32'h0);
            drive_p1(1'b1, 1'b0, 32'h60, 32'h0);
            #3;
            chk($sformatf("fp_addr_%0d", k), f_mem_req.address, 32'h50);
            chk($sformatf("fp_p0_wait_%0d", k), 32'(f_p0_resp.waitrequest), 32'd0);
            chk($sformatf("fp_p1_wait_%0d", k), 32'(f_p1_resp.waitrequest), 32'd1);
            step();
        end

        // Read latency 3: p0 read at c0, p1 read at c1 -> data at c3, c4
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            idle_all();
            if (k == 0) drive_p0(1'b1, 1'b0, 32'h40, 32'h0);
            if (k == 1) drive_p1(1'b1, 1'b0, 32'h44, 32'h0);
            mem_resp.readdata = 32'hB000 + 32'(k);
            #3;
            if (k >= 2) begin
                chk($sformatf("l3_p0_rdata_%0d", k), l_p0_resp.readdata, (k == 3) ? 32'hB003 : 32'h0);
                chk($sformatf("l3_p1_rdata_%0d", k), l_p1_resp.readdata, (k == 4) ? 32'hB004 : 32'h0);
            end
            step();
        end

        // Async reset mid-LOCKED
        pulse_reset();
        idle_all();
        drive_p0(1'b1, 1'b0, 32'h500, 32'h0);
        drive_p1(1'b1, 1'b0, 32'h600, 32'h0);
        mem_resp.waitrequest = 1'b1;
        #3;
        chk("arst_pre_addr", d_mem_req.address, 32'h500);
        step();
        #2;
        chk("arst_locked_read", 32'(d_mem_req.read), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_read", 32'(d_mem_req.read), 32'd0);
        chk("arst_mem_write", 32'(d_mem_req.write), 32'd0);
        chk("arst_p0_wait", 32'(d_p0_resp.waitrequest), 32'd1);
        step();
        rst = 1'b0;
        mem_resp.waitrequest = 1'b0;
        drive_p0(1'b1, 1'b0, 32'h510, 32'h0);
        drive_p1(1'b1, 1'b0, 32'h610, 32'h0);
        #3;
        chk("arst_after_addr", d_mem_req.address, 32'h510);
        chk("arst_after_p1_wait", 32'(d_p1_resp.waitrequest), 32'd1);
        chk("arst_after_p0_wait", 32'(d_p0_resp.waitrequest), 32'd0);
        step();
        idle_all();
        #3;
        chk("arst_after_p0_rdata", d_p0_resp.readdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
